// File: rtl/parity_frame_serializer.sv
// parity_frame_serializer: takes a word on a valid/ready handshake and
// shifts it out MSB first, followed by one parity bit and IDLE_GAP idle cycles.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready word input;
//   ser_out/ser_valid serial stream; frame_start/frame_end bit markers; busy.
// Optional macro PARITY_SERIALIZER_ERRINJ_EN adds err_inj (sampled at accept,
//   inverts that frame's parity bit) and err_sent (pulses with that parity bit).
module parity_frame_serializer #(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0,
  parameter int IDLE_GAP   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
`ifdef PARITY_SERIALIZER_ERRINJ_EN
  input  logic              err_inj,
  output logic              err_sent,
`endif
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              frame_end,
  output logic              busy
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    GAP
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              par_q, par_d;
  logic              so_q, so_d;
  logic              sv_q, sv_d;
  logic              fs_q, fs_d;
  logic              fe_q, fe_d;
  logic              busy_q, busy_d;
  logic              inj_in;
`ifdef PARITY_SERIALIZER_ERRINJ_EN
  logic              inj_q, inj_d;
  logic              es_q, es_d;
  assign inj_in = err_inj;
`else
  assign inj_in = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    par_d   = par_q;
    so_d    = 1'b0;
    sv_d    = 1'b0;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef PARITY_SERIALIZER_ERRINJ_EN
    inj_d   = inj_q;
    es_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DATA;
          // MSB leaves now; the register holds the remaining bits
          shreg_d = {in_data[DATA_W-2:0], 1'b0};
          cnt_d   = CW'(1);
          par_d   = (^in_data) ^ (PARITY_ODD != 0) ^ inj_in;
          so_d    = in_data[DATA_W-1];
          sv_d    = 1'b1;
          fs_d    = 1'b1;
`ifdef PARITY_SERIALIZER_ERRINJ_EN
          inj_d   = err_inj;
`endif
        end
      end
      DATA: begin
        sv_d = 1'b1;
        if (cnt_q >= CW'(DATA_W)) begin
          state_d = PARITY;
          cnt_d   = '0;
          so_d    = par_q;
          fe_d    = 1'b1;
`ifdef PARITY_SERIALIZER_ERRINJ_EN
          es_d    = inj_q;
`endif
        end else begin
          so_d    = shreg_q[DATA_W-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PARITY: begin
`ifdef PARITY_SERIALIZER_ERRINJ_EN
        inj_d = 1'b0;
`endif
        if (IDLE_GAP > 0) begin
          state_d = GAP;
          gap_d   = GW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q >= GW'(IDLE_GAP)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      par_q   <= 1'b0;
      so_q    <= 1'b0;
      sv_q    <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PARITY_SERIALIZER_ERRINJ_EN
      inj_q   <= 1'b0;
      es_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      par_q   <= par_d;
      so_q    <= so_d;
      sv_q    <= sv_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      busy_q  <= busy_d;
`ifdef PARITY_SERIALIZER_ERRINJ_EN
      inj_q   <= inj_d;
      es_q    <= es_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign ser_out     = so_q;
  assign ser_valid   = sv_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;
  assign busy        = busy_q;
`ifdef PARITY_SERIALIZER_ERRINJ_EN
  assign err_sent    = es_q;
`endif

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Bench for parity_frame_serializer: instance A is even parity with a one-cycle
// gap, instance B is odd parity with no gap; a scoreboard checks every frame bit.
module tb_parity_frame_serializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] data_a, data_b;
  logic valid_a, ready_a, so_a, sv_a, fs_a, fe_a, busy_a;
  logic valid_b, ready_b, so_b, sv_b, fs_b, fe_b, busy_b;
  logic inj_a, es_a, es_b;

  parity_frame_serializer #(
    .DATA_W(W), .PARITY_ODD(0), .IDLE_GAP(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .in_data(data_a), .in_valid(valid_a),
`ifdef PARITY_SERIALIZER_ERRINJ_EN
    .err_inj(inj_a), .err_sent(es_a),
`endif
    .in_ready(ready_a), .ser_out(so_a),
    .ser_valid(sv_a), .frame_start(fs_a),
    .frame_end(fe_a), .busy(busy_a)
  );

  parity_frame_serializer #(
    .DATA_W(W), .PARITY_ODD(1), .IDLE_GAP(0)
  ) u_b (
    .clk(clk), .rst(rst),
    .in_data(data_b), .in_valid(valid_b),
`ifdef PARITY_SERIALIZER_ERRINJ_EN
    .err_inj(1'b0), .err_sent(es_b),
`endif
    .in_ready(ready_b), .ser_out(so_b),
    .ser_valid(sv_b), .frame_start(fs_b),
    .frame_end(fe_b), .busy(busy_b)
  );

`ifndef PARITY_SERIALIZER_ERRINJ_EN
  assign es_a = 1'b0;
  assign es_b = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic fs;
    logic fe;
    logic es;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   acc_a[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  task automatic push_a(input logic [W-1:0] d, input logic inj);
    exp_t e;
    for (int i = W - 1; i >= 0; i--) begin
      e = '{b: d[i], fs: (i == W - 1), fe: 1'b0, es: 1'b0};
      qa.push_back(e);
    end
    e = '{b: (^d) ^ inj, fs: 1'b0, fe: 1'b1, es: inj};
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [W-1:0] d);
    exp_t e;
    for (int i = W - 1; i >= 0; i--) begin
      e = '{b: d[i], fs: (i == W - 1), fe: 1'b0, es: 1'b0};
      qb.push_back(e);
    end
    e = '{b: ~(^d), fs: 1'b0, fe: 1'b1, es: 1'b0};
    qb.push_back(e);
  endtask

  // one clock: log accepted words into the scoreboard, then compare outputs
  task automatic cyc();
    logic         acc_a_now, acc_b_now, ia;
    logic [W-1:0] da, db;
    exp_t         e, g;
    acc_a_now = !rst && valid_a && ready_a;
    acc_b_now = !rst && valid_b && ready_b;
    da = data_a;
    db = data_b;
    ia = inj_a;
    @(posedge clk);
    cycle++;
    if (acc_a_now) begin
      push_a(da, ia);
      acc_a.push_back(cycle);
    end
    if (acc_b_now) push_b(db);
    @(negedge clk);
    checks++;
    if (sv_a) begin
      g = '{b: so_a, fs: fs_a, fe: fe_a, es: es_a};
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL sb_a_extra: bit %b seen, none expected", g);
      end else begin
        e = qa.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL sb_a: got %b want %b", g, e);
        end
      end
    end else if ({so_a, fs_a, fe_a, es_a} !== 4'b0) begin
      errors++;
      $display("FAIL idle_a: got %b want 0000",
               {so_a, fs_a, fe_a, es_a});
    end
    checks++;
    if (sv_b) begin
      g = '{b: so_b, fs: fs_b, fe: fe_b, es: es_b};
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL sb_b_extra: bit %b seen, none expected", g);
      end else begin
        e = qb.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL sb_b: got %b want %b", g, e);
        end
      end
    end else if ({so_b, fs_b, fe_b, es_b} !== 4'b0) begin
      errors++;
      $display("FAIL idle_b: got %b want 0000",
               {so_b, fs_b, fe_b, es_b});
    end
    checks++;
    if (busy_a !== !ready_a || busy_b !== !ready_b) begin
      errors++;
      $display("FAIL busy_ready: busy %b%b ready %b%b",
               busy_a, busy_b, ready_a, ready_b);
    end
  endtask

  // counts ones of the frame in progress until frame_end, bounded
  task automatic wait_fe_a(output int ones, output bit ok);
    ones = 0;
    ok   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (sv_a) ones += int'(so_a);
      if (fe_a) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic wait_fe_b(output int ones, output bit ok);
    ones = 0;
    ok   = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (sv_b) ones += int'(so_b);
      if (fe_b) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    checks++;
    if ({ready_a, busy_a, sv_a, so_a, fs_a, fe_a} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_a: rdy/busy/sv/so/fs/fe=%b want 100000",
               {ready_a, busy_a, sv_a, so_a, fs_a, fe_a});
    end
    checks++;
    if ({ready_b, busy_b, sv_b, so_b, fs_b, fe_b} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_b: rdy/busy/sv/so/fs/fe=%b want 100000",
               {ready_b, busy_b, sv_b, so_b, fs_b, fe_b});
    end
  endtask

  task automatic test_frame_a5();
    logic [8:0] seq;
    logic [8:0] fes;
    logic       fs0;
    seq = '0;
    fes = '0;
    data_a  = 8'hA5;
    valid_a = 1'b1;
    cyc();
    valid_a = 1'b0;
    data_a  = 8'h5A;
    fs0 = fs_a;
    for (int i = 0; i < 9; i++) begin
      seq = {seq[7:0], so_a};
      fes = {fes[7:0], fe_a};
      cyc();
    end
    checks++;
    if (seq !== 9'b1_0100_1010) begin
      errors++;
      $display("FAIL a5_bits: got %b want 101001010", seq);
    end
    checks++;
    if (fes !== 9'b0_0000_0001 || fs0 !== 1'b1) begin
      errors++;
      $display("FAIL a5_marks: fe %b fs %b want 000000001 1", fes, fs0);
    end
    checks++;
    if (ready_a !== 1'b0) begin
      errors++;
      $display("FAIL a5_gap_ready: got %b want 0", ready_a);
    end
    cyc();
    checks++;
    if (ready_a !== 1'b1) begin
      errors++;
      $display("FAIL a5_ready_back: got %b want 1", ready_a);
    end
  endtask

  task automatic test_parity_01();
    int ones;
    bit ok;
    data_a  = 8'h01;
    valid_a = 1'b1;
    cyc();
    valid_a = 1'b0;
    wait_fe_a(ones, ok);
    checks++;
    if (!ok || so_a !== 1'b1) begin
      errors++;
      $display("FAIL p01_parity: ok %0d bit %b want 1 1", ok, so_a);
    end
    checks++;
    if (ones % 2 != 0) begin
      errors++;
      $display("FAIL p01_checker_even: ones %0d want even", ones);
    end
    cyc();
    cyc();
  endtask

  task automatic test_back_to_back();
    acc_a.delete();
    data_a  = 8'hFF;
    valid_a = 1'b1;
    for (int i = 0; i < 40 && acc_a.size() < 2; i++) begin
      cyc();
      if (acc_a.size() == 1) data_a = 8'h80;
    end
    valid_a = 1'b0;
    for (int i = 0; i < 40 && qa.size() > 0; i++) cyc();
    checks++;
    if (acc_a.size() != 2) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d want 2", acc_a.size());
    end else begin
      checks++;
      if (acc_a[1] - acc_a[0] != 11) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d want 11",
                 acc_a[1] - acc_a[0]);
      end
    end
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d bits left want 0", qa.size());
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int fe_seen;
    fe_seen = 0;
    data_a  = 8'h3C;
    valid_a = 1'b1;
    cyc();
    valid_a = 1'b0;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    qa.delete();
    cyc();
    rst = 1'b0;
    checks++;
    if ({busy_a, sv_a, ready_a} !== 3'b001) begin
      errors++;
      $display("FAIL rstmid_state: busy/sv/rdy=%b want 001",
               {busy_a, sv_a, ready_a});
    end
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (fe_a) fe_seen++;
    end
    checks++;
    if (fe_seen != 0) begin
      errors++;
      $display("FAIL rstmid_no_fe: got %0d want 0", fe_seen);
    end
  endtask

  task automatic test_odd_gap0();
    int ones;
    bit ok;
    data_b  = 8'h00;
    valid_b = 1'b1;
    cyc();
    valid_b = 1'b0;
    wait_fe_b(ones, ok);
    checks++;
    if (!ok || so_b !== 1'b1 || ready_b !== 1'b0) begin
      errors++;
      $display("FAIL odd_parity: ok %0d bit %b rdy %b want 1 1 0",
               ok, so_b, ready_b);
    end
    checks++;
    if (ones % 2 != 1) begin
      errors++;
      $display("FAIL odd_checker: ones %0d want odd", ones);
    end
    cyc();
    checks++;
    if (ready_b !== 1'b1) begin
      errors++;
      $display("FAIL gap0_ready: got %b want 1", ready_b);
    end
    cyc();
  endtask

`ifdef PARITY_SERIALIZER_ERRINJ_EN
  task automatic test_errinj();
    int ones;
    bit ok;
    data_a  = 8'h03;
    valid_a = 1'b1;
    inj_a   = 1'b1;
    cyc();
    valid_a = 1'b0;
    inj_a   = 1'b0;
    wait_fe_a(ones, ok);
    checks++;
    if (!ok || so_a !== 1'b1 || es_a !== 1'b1) begin
      errors++;
      $display("FAIL inj_bad: ok %0d bit %b sent %b want 1 1 1",
               ok, so_a, es_a);
    end
    cyc();
    cyc();
    valid_a = 1'b1;
    cyc();
    valid_a = 1'b0;
    wait_fe_a(ones, ok);
    checks++;
    if (!ok || so_a !== 1'b0 || es_a !== 1'b0) begin
      errors++;
      $display("FAIL inj_clean: ok %0d bit %b sent %b want 1 0 0",
               ok, so_a, es_a);
    end
    cyc();
    cyc();
  endtask
`endif

  initial begin
    rst     = 1'b1;
    data_a  = '0;
    data_b  = '0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    inj_a   = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame_a5();
    test_parity_01();
    test_back_to_back();
    test_reset_mid();
    test_odd_gap0();
`ifdef PARITY_SERIALIZER_ERRINJ_EN
    test_errinj();
`endif
    for (int i = 0; i < 15; i++) cyc();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL final_drain: left a %0d b %0d want 0 0",
               qa.size(), qb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
